// File: rtl/alu_pkg.sv
// Shared definitions for the advanced ALU: FSM states, data width and the
// butterfly stage masks/shift amounts used by the shuffle engine.
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Indexed by stage number k; element 0 is stage 0.
  localparam logic [DATA_W-1:0] STAGE_L [4] = '{
    32'h44444444, 32'h30303030, 32'h0F000F00, 32'h00FF0000
  };
  localparam logic [DATA_W-1:0] STAGE_R [4] = '{
    32'h22222222, 32'h0C0C0C0C, 32'h00F000F0, 32'h0000FF00
  };
  localparam int unsigned STAGE_N [4] = '{1, 2, 4, 8};

endpackage

// File: rtl/alu_shfl_stage.sv
// One butterfly stage of the zip/unzip network; each stage swaps its L and R
// bit groups, so applying it twice restores the input.
module alu_shfl_stage
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [1:0]        idx,
  input  logic              en,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W-1:0] l_m;
  logic [DATA_W-1:0] r_m;
  logic [DATA_W-1:0] swapped;

  always_comb begin
    l_m     = STAGE_L[idx];
    r_m     = STAGE_R[idx];
    swapped = (x & ~(l_m | r_m))
            | ((x << STAGE_N[idx]) & l_m)
            | ((x >> STAGE_N[idx]) & r_m);
    y       = en ? swapped : x;
  end

endmodule

// File: rtl/alu_shfl_iter.sv
// Iterative shfl/unshfl engine: one butterfly stage per cycle over four cycles.
// Handshake: a transfer happens on an edge where valid and ready are both 1.
module alu_shfl_iter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  input  logic [3:0]        ctrl,
  input  logic              mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res
);

  state_t            state;
  logic [1:0]        cnt;
  logic [DATA_W-1:0] data;
  logic [3:0]        ctrl_q;
  logic              mode_q;
  logic [1:0]        stage_idx;
  logic [DATA_W-1:0] stage_y;

  // Zip walks the stages from widest to narrowest, unzip the reverse.
  assign stage_idx = mode_q ? cnt : 2'd3 - cnt;

  alu_shfl_stage u_stage (
    .x   (data),
    .idx (stage_idx),
    .en  (ctrl_q[stage_idx]),
    .y   (stage_y)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign res       = data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= 2'd0;
      data   <= '0;
      ctrl_q <= 4'd0;
      mode_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            data   <= din;
            ctrl_q <= ctrl;
            mode_q <= mode;
            cnt    <= 2'd0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          data <= stage_y;
          cnt  <= cnt + 2'd1;
          if (cnt == 2'd3) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shfl_iter.sv
// Directed-vector bench for alu_shfl_iter: table of hand-computed results,
// random round trips, backpressure and mid-operation reset sequences.
module tb_alu_shfl_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] din;
  logic [3:0]  ctrl;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] din;
    logic [3:0]  ctrl;
    logic        mode;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  alu_shfl_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .ctrl      (ctrl),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Waits for out_valid after an acceptance edge; lat = edges from acceptance.
  task automatic wait_result(output logic [31:0] r, output int lat);
    lat = 0;
    r   = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      lat = n;
      if (out_valid) break;
    end
    r = res;
  endtask

  // Issues one request, scrambles the inputs right after acceptance, and
  // returns the result once out_ready has consumed it.
  task automatic do_op(input logic [31:0] d, input logic [3:0] c, input logic m,
                       output logic [31:0] r, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    din      = d;
    ctrl     = c;
    mode     = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    din      = $urandom;
    ctrl     = 4'($urandom);
    mode     = 1'($urandom);
    wait_result(r, lat);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r, y, z, x;
    logic [3:0]  c;
    int          lat;

    vecs[0]  = '{32'h0000FFFF, 4'b1111, 1'b0, 32'h55555555};
    vecs[1]  = '{32'hFFFF0000, 4'b1111, 1'b0, 32'hAAAAAAAA};
    vecs[2]  = '{32'h55555555, 4'b1111, 1'b1, 32'h0000FFFF};
    vecs[3]  = '{32'hAAAAAAAA, 4'b1111, 1'b1, 32'hFFFF0000};
    vecs[4]  = '{32'h12345678, 4'b1000, 1'b0, 32'h12563478};
    vecs[5]  = '{32'h12345678, 4'b1000, 1'b1, 32'h12563478};
    vecs[6]  = '{32'h12345678, 4'b0000, 1'b0, 32'h12345678};
    vecs[7]  = '{32'hDEADBEEF, 4'b0000, 1'b1, 32'hDEADBEEF};
    vecs[8]  = '{32'h00000002, 4'b0001, 1'b0, 32'h00000004};
    vecs[9]  = '{32'h000000F0, 4'b0100, 1'b0, 32'h00000F00};
    vecs[10] = '{32'h0000000C, 4'b0010, 1'b1, 32'h00000030};

    // Clock/reset
    rst = 1'b1; in_valid = 1'b0; din = '0; ctrl = '0; mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset res", res, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      do_op(vecs[i].din, vecs[i].ctrl, vecs[i].mode, r, lat);
      check($sformatf("vec%0d res", i), r, vecs[i].exp);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
    end

    // Random round trips
    for (int i = 0; i < 1000; i++) begin
      x = $urandom;
      c = 4'($urandom);
      do_op(x, c, 1'b0, y, lat);
      do_op(y, c, 1'b1, z, lat);
      check($sformatf("roundtrip x=%h ctrl=%b", x, c), z, x);
    end

    // Backpressure: result held, second request refused until release
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; din = 32'h0000FFFF; ctrl = 4'b1111; mode = 1'b0;
    @(posedge clk); #1;
    din = 32'hFFFF0000;
    wait_result(r, lat);
    check("bp latency", 32'(lat), 32'd4);
    check("bp res", r, 32'h55555555);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp hold res", res, 32'h55555555);
      check("bp hold out_valid", 32'(out_valid), 32'd1);
      check("bp hold in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release in_ready", 32'(in_ready), 32'd1);
    check("bp release out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("bp next accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_result(r, lat);
    check("bp next latency", 32'(lat), 32'd4);
    check("bp next res", r, 32'hAAAAAAAA);
    @(posedge clk); #1;

    // Reset in the middle of RUN
    @(negedge clk);
    in_valid = 1'b1; din = 32'h12345678; ctrl = 4'b1111; mode = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrun rst out_valid", 32'(out_valid), 32'd0);
    check("midrun rst res", res, 32'h0);
    check("midrun rst in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrun no stale result", 32'(out_valid), 32'd0);
    do_op(32'h0000FFFF, 4'b1111, 1'b0, r, lat);
    check("post reset res", r, 32'h55555555);
    check("post reset latency", 32'(lat), 32'd4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
